// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencing FSM states, forwarding-select codes and the NOP encoding.
package cpu_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } seq_state_e;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count register, frozen once every bit is set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= {W{1'b0}};
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble/flush sequencing for load-use, EX redirects and data-memory waits,
// with saturating performance counters and a sticky memory-timeout flag.
module hazard_stall_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IFID_rs1,
   input  logic [4:0]       IFID_rs2,
   input  logic             IFID_uses_rs1,
   input  logic             IFID_uses_rs2,
   input  logic [4:0]       IDEX_rd,
   input  logic             IDEX_MemRead,
   input  logic             EX_redirect,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             mem_timeout
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   seq_state_e        state_r;
   seq_state_e        state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_nxt_s;
   logic              mem_timeout_r;
   logic              memwait_s;
   logic              loaduse_s;
   logic              stall_inc_s;
   logic              flush_inc_s;

   // Hazard detection and priority-encoded pipeline controls.
   always_comb begin
      memwait_s  = dmem_req & ~dmem_ready;
      loaduse_s  = IDEX_MemRead & (IDEX_rd != 5'd0) &
                   ((IFID_uses_rs1 & (IDEX_rd == IFID_rs1)) |
                    (IFID_uses_rs2 & (IDEX_rd == IFID_rs2)));
      PC_write   = 1'b1;
      IFID_write = 1'b1;
      IFID_flush = 1'b0;
      IDEX_flush = 1'b0;
      pipe_hold  = 1'b0;
      if (reset) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IFID_flush = 1'b1;
         IDEX_flush = 1'b1;
      end else if (memwait_s) begin
         // EX is frozen, so a redirect or load-use stays pending until ready.
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         pipe_hold  = 1'b1;
      end else if (EX_redirect) begin
         IFID_flush = 1'b1;
         IDEX_flush = 1'b1;
      end else if (loaduse_s) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IDEX_flush = 1'b1;
      end else begin
         PC_write   = 1'b1;
      end
      stall_inc_s = ~reset & ~PC_write;
      flush_inc_s = ~reset & ~memwait_s & EX_redirect;
   end

   // Next state and consecutive-wait count; a dropped request exits without a timeout.
   always_comb begin
      state_nxt_s = RUN;
      wait_nxt_s  = {WAIT_W{1'b0}};
      case (state_r)
         RUN: begin
            if (memwait_s) begin
               state_nxt_s = MEM_WAIT;
               wait_nxt_s  = WAIT_W'(1);
            end else begin
               state_nxt_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (memwait_s) begin
               state_nxt_s = MEM_WAIT;
               wait_nxt_s  = (wait_cnt_r == WAIT_MAX) ? WAIT_MAX : wait_cnt_r + WAIT_W'(1);
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // State, wait counter and sticky timeout registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= RUN;
         wait_cnt_r    <= {WAIT_W{1'b0}};
         mem_timeout_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         if (wait_nxt_s == WAIT_MAX) begin
            mem_timeout_r <= 1'b1;
         end
      end
   end

   assign mem_timeout = mem_timeout_r;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc_s),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc_s),
      .count (flush_events)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed and randomized checks of hazard_stall_ctrl against a priority-rule reference model.
module tb_hazard_stall_ctrl;

   localparam int CNT_W    = 6;
   localparam int MAX_WAIT = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       IFID_rs1, IFID_rs2, IDEX_rd;
   logic             IFID_uses_rs1, IFID_uses_rs2, IDEX_MemRead;
   logic             EX_redirect, dmem_req, dmem_ready;
   logic             PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_hold, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   int checks = 0;
   int errors = 0;
   int m_stall, m_flush, m_wait;
   bit m_to;

   hazard_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
      .IFID_uses_rs1(IFID_uses_rs1), .IFID_uses_rs2(IFID_uses_rs2),
      .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead),
      .EX_redirect(EX_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
      .IDEX_flush(IDEX_flush), .pipe_hold(pipe_hold),
      .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit red, input bit req, input bit rdy);
      IFID_rs1      = 5'(rs1);
      IFID_rs2      = 5'(rs2);
      IFID_uses_rs1 = u1;
      IFID_uses_rs2 = u2;
      IDEX_rd       = 5'(rd);
      IDEX_MemRead  = mr;
      EX_redirect   = red;
      dmem_req      = req;
      dmem_ready    = rdy;
   endtask

   // One cycle: predict controls from the rules, compare, clock, then advance the model.
   task automatic step(input string tag);
      bit mw, lu;
      bit e_pc, e_ifw, e_iff, e_idf, e_hold;
      #1;
      mw = dmem_req && !dmem_ready;
      lu = IDEX_MemRead && (IDEX_rd != 0) &&
           ((IFID_uses_rs1 && IDEX_rd == IFID_rs1) || (IFID_uses_rs2 && IDEX_rd == IFID_rs2));
      if (mw)               {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00001;
      else if (EX_redirect) {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11110;
      else if (lu)          {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00010;
      else                  {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11000;
      chk({tag, ".PC_write"},   32'(PC_write),   32'(e_pc));
      chk({tag, ".IFID_write"}, 32'(IFID_write), 32'(e_ifw));
      chk({tag, ".IFID_flush"}, 32'(IFID_flush), 32'(e_iff));
      chk({tag, ".IDEX_flush"}, 32'(IDEX_flush), 32'(e_idf));
      chk({tag, ".pipe_hold"},  32'(pipe_hold),  32'(e_hold));
      chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
      chk({tag, ".flush_events"}, 32'(flush_events), 32'(m_flush));
      chk({tag, ".mem_timeout"},  32'(mem_timeout),  32'(m_to));
      @(posedge clk);
      if (!e_pc && m_stall < CNT_MAX) m_stall++;
      if (!mw && EX_redirect && m_flush < CNT_MAX) m_flush++;
      if (mw) begin
         if (m_wait < MAX_WAIT) m_wait++;
         if (m_wait == MAX_WAIT) m_to = 1'b1;
      end else begin
         m_wait = 0;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_stall = 0;
      m_flush = 0;
      m_wait  = 0;
      m_to    = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".PC_write"},   32'(PC_write),   32'd0);
      chk({tag, ".IFID_write"}, 32'(IFID_write), 32'd0);
      chk({tag, ".IFID_flush"}, 32'(IFID_flush), 32'd1);
      chk({tag, ".IDEX_flush"}, 32'(IDEX_flush), 32'd1);
      chk({tag, ".pipe_hold"},  32'(pipe_hold),  32'd0);
      chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
      chk({tag, ".flush_events"}, 32'(flush_events), 32'd0);
      chk({tag, ".mem_timeout"},  32'(mem_timeout),  32'd0);
   endtask

   initial begin
      reset = 1'b1;
      model_reset();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Load x5 in EX, ID reads x5 through rs1: one bubble
      apply(5, 7, 1, 1, 5, 1, 0, 0, 0);
      step("loaduse_rs1");
      apply(5, 7, 1, 1, 9, 0, 0, 0, 0);
      step("after_bubble");
      chk("loaduse_stall_cnt", 32'(stall_cycles), 32'd1);

      // Load x0 never stalls; rs2 hit only when rs2 is actually read
      apply(0, 0, 1, 1, 0, 1, 0, 0, 0);
      step("load_x0");
      apply(3, 6, 1, 0, 6, 1, 0, 0, 0);
      step("rs2_unused");
      apply(3, 6, 0, 1, 6, 1, 0, 0, 0);
      step("loaduse_rs2");

      // Redirect beats a simultaneous load-use
      apply(5, 5, 1, 1, 5, 1, 1, 0, 0);
      step("redirect_over_lu");
      chk("redirect_flush_cnt", 32'(flush_events), 32'd1);

      // Three wait cycles with a pending redirect, then ready
      for (int i = 0; i < 3; i++) begin
         apply(1, 2, 1, 1, 4, 0, 1, 1, 0);
         step("wait_redirect");
      end
      apply(1, 2, 1, 1, 4, 0, 1, 1, 1);
      step("ready_redirect");
      chk("wait_stall_cnt", 32'(stall_cycles), 32'd5);
      chk("wait_flush_cnt", 32'(flush_events), 32'd2);

      // Dropped request mid-wait exits without a timeout
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("proto_wait1");
      step("proto_wait2");
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("proto_drop");
      chk("proto_no_timeout", 32'(mem_timeout), 32'd0);

      // Six wait cycles: timeout rises after the fourth and sticks
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step("long_wait");
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step("long_ready");
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("timeout_sticky");
      chk("timeout_set", 32'(mem_timeout), 32'd1);

      // Reset in the middle of a memory wait
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("pre_reset_wait");
      reset = 1'b1;
      #1;
      model_reset();
      chk_reset_outputs("mid_wait_reset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("post_reset");

      // Random traffic biased toward register collisions; counters saturate
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) != 0));
         step("random");
      end
      step("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
